// File: rtl/mdu.sv
// Iterative RV64M multiply/divide: one-cycle multiply, restoring divide (one bit per cycle), then a sign/special-case fix cycle.
// Latency 2 (mul, special-case div), 34 (word div), 66 (64-bit div); start is ignored while busy, flush aborts.
module mdu #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t      state, state_nxt;
  logic [3:0]  op_r;
  logic [63:0] a_r, b_r;
  logic [63:0] quo, rem, dvs;
  logic [6:0]  cnt;
  logic        neg_q, neg_r, div0_r, ovf_r;

  function automatic logic [63:0] sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  logic accept;
  assign accept = start && !busy && !flush;

  // Operand preparation at the op width, done in IDLE so special cases skip the iterations.
  logic        w_in, sgn_in, neg_a, neg_b, div0, ovf;
  logic [63:0] da, db, mag_a, mag_b;
  always_comb begin
    w_in   = op[3];
    sgn_in = ~op[0];
    da     = w_in ? (sgn_in ? sext32(a[31:0]) : {32'b0, a[31:0]}) : a;
    db     = w_in ? (sgn_in ? sext32(b[31:0]) : {32'b0, b[31:0]}) : b;
    neg_a  = sgn_in && da[63];
    neg_b  = sgn_in && db[63];
    mag_a  = neg_a ? -da : da;
    mag_b  = neg_b ? -db : db;
    div0   = (db == 64'd0);
    ovf    = sgn_in && (db == '1) &&
             (w_in ? (da == 64'hFFFF_FFFF_8000_0000) : (da == 64'h8000_0000_0000_0000));
  end

  logic [127:0] ma, mb, prod;
  logic [63:0]  mul_res;
  logic         a_s, b_s;
  always_comb begin
    a_s  = (op_r[2:0] == 3'b001) || (op_r[2:0] == 3'b010);
    b_s  = (op_r[2:0] == 3'b001);
    ma   = {{64{a_s & a_r[63]}}, a_r};
    mb   = {{64{b_s & b_r[63]}}, b_r};
    prod = ma * mb;
    if (op_r[3])
      mul_res = sext32(prod[31:0]);
    else if (op_r[2:0] == 3'b000)
      mul_res = prod[63:0];
    else
      mul_res = prod[127:64];
  end

  logic [64:0] r_shift;
  logic [63:0] r_diff, rem_nxt;
  logic        ge;
  always_comb begin
    r_shift = {rem, quo[63]};
    ge      = r_shift >= {1'b0, dvs};
    r_diff  = r_shift[63:0] - dvs;
    rem_nxt = ge ? r_diff : r_shift[63:0];
  end

  logic [63:0] q_fix, r_fix, raw, fix_res;
  always_comb begin
    q_fix = neg_q ? -quo : quo;
    r_fix = neg_r ? -rem : rem;
    if (div0_r) begin
      q_fix = '1;
      r_fix = a_r;
    end else if (ovf_r) begin
      q_fix = a_r;
      r_fix = 64'd0;
    end
    raw     = op_r[1] ? r_fix : q_fix;
    fix_res = op_r[3] ? sext32(raw[31:0]) : raw;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = !op[2] ? MUL : ((div0 || ovf) ? FIX : DIV);
      MUL:  state_nxt = IDLE;
      DIV:  if (cnt == 7'd1) state_nxt = FIX;
      FIX:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  always_comb begin
    busy = (state != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r   <= '0;
      a_r    <= '0;
      b_r    <= '0;
      quo    <= '0;
      rem    <= '0;
      dvs    <= '0;
      cnt    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      div0_r <= 1'b0;
      ovf_r  <= 1'b0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        op_r   <= op;
        a_r    <= a;
        b_r    <= b;
        // Word dividends sit in the top half so 32 shifts leave the quotient in the low half.
        quo    <= w_in ? {mag_a[31:0], 32'b0} : mag_a;
        rem    <= '0;
        dvs    <= mag_b;
        cnt    <= w_in ? 7'd32 : 7'd64;
        neg_q  <= neg_a ^ neg_b;
        neg_r  <= neg_a;
        div0_r <= div0;
        ovf_r  <= ovf && !div0;
      end else if (!flush) begin
        case (state)
          DIV: begin
            rem <= rem_nxt;
            quo <= {quo[62:0], ge};
            cnt <= cnt - 7'd1;
          end
          MUL: begin
            result <= mul_res;
            done   <= 1'b1;
          end
          FIX: begin
            result <= fix_res;
            done   <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mdu.sv
// Randomized and directed bench for mdu against an arithmetic reference model.
module tb_mdu;
  logic        clk, rst_n, start, flush;
  logic [3:0]  op;
  logic [63:0] a, b;
  logic        busy, done;
  logic [63:0] result;

  int errors = 0;
  int checks = 0;

  mdu #(.XLEN(64)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .busy(busy), .done(done), .result(result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] sx(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  function automatic logic [63:0] ref_res(input logic [3:0] o, input logic [63:0] x, input logic [63:0] y);
    logic [127:0] xa, yb, p;
    logic [31:0]  x32, y32, q32, r32;
    logic [63:0]  q64, r64;
    logic         sg;
    sg = !o[0];
    if (!o[2]) begin
      if (o[3]) begin
        p = {64'b0, x} * {64'b0, y};
        return sx(p[31:0]);
      end
      xa = (o[2:0] == 3'b011) ? {64'b0, x} : {{64{x[63]}}, x};
      yb = (o[2:0] == 3'b001) ? {{64{y[63]}}, y} : {64'b0, y};
      p  = xa * yb;
      return (o[2:0] == 3'b000) ? p[63:0] : p[127:64];
    end
    if (o[3]) begin
      x32 = x[31:0];
      y32 = y[31:0];
      if (y32 == 0) begin
        q32 = '1; r32 = x32;
      end else if (sg && x32 == 32'h8000_0000 && y32 == '1) begin
        q32 = x32; r32 = 0;
      end else if (sg) begin
        q32 = $signed(x32) / $signed(y32);
        r32 = $signed(x32) % $signed(y32);
      end else begin
        q32 = x32 / y32;
        r32 = x32 % y32;
      end
      return sx(o[1] ? r32 : q32);
    end
    if (y == 0) begin
      q64 = '1; r64 = x;
    end else if (sg && x == 64'h8000_0000_0000_0000 && y == '1) begin
      q64 = x; r64 = 0;
    end else if (sg) begin
      q64 = $signed(x) / $signed(y);
      r64 = $signed(x) % $signed(y);
    end else begin
      q64 = x / y;
      r64 = x % y;
    end
    return o[1] ? r64 : q64;
  endfunction

  function automatic int ref_lat(input logic [3:0] o, input logic [63:0] x, input logic [63:0] y);
    logic sg;
    sg = !o[0];
    if (!o[2]) return 2;
    if (o[3]) begin
      if (y[31:0] == 0 || (sg && x[31:0] == 32'h8000_0000 && y[31:0] == '1)) return 2;
      return 34;
    end
    if (y == 0 || (sg && x == 64'h8000_0000_0000_0000 && y == '1)) return 2;
    return 66;
  endfunction

  function automatic logic [63:0] rnd64();
    case ($urandom_range(0, 6))
      0: return 64'd0;
      1: return '1;
      2: return 64'h8000_0000_0000_0000;
      3: return 64'($urandom_range(0, 20));
      4: return 64'hFFFF_FFFF_8000_0000;
      5: return {32'b0, $urandom};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // Issues one op, optionally holding start high (with junk operands) for the first cycles of busy.
  task automatic run_op(input string tag, input logic [3:0] o, input logic [63:0] x,
                        input logic [63:0] y, input int hold);
    int k, lat;
    logic busy_ok;
    logic [63:0] exp;
    exp = ref_res(o, x, y);
    lat = ref_lat(o, x, y);
    busy_ok = 1'b1;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    for (k = 1; k <= 80; k++) begin
      #1;
      if (done) break;
      if (!busy) busy_ok = 1'b0;
      @(negedge clk);
      start = (k < hold);
      if (start) begin
        op = 4'($urandom); a = rnd64(); b = rnd64();
      end
      @(posedge clk);
    end
    check({tag, "_lat"}, 64'(k), 64'(lat));
    check({tag, "_busy"}, {63'b0, busy_ok}, 64'd1);
    check({tag, "_busy_done"}, {63'b0, busy}, 64'd0);
    check({tag, "_res"}, result, exp);
  endtask

  initial begin
    logic [63:0] prev;
    logic seen;
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
    #12;
    check("rst_busy", {63'b0, busy}, 64'd0);
    check("rst_done", {63'b0, done}, 64'd0);
    check("rst_res", result, 64'd0);
    @(negedge clk); rst_n = 1'b1;

    run_op("mul", 4'b0000, '1, 64'd3, 0);
    run_op("mulhu", 4'b0011, '1, 64'd3, 0);
    run_op("div", 4'b0100, -64'd7, 64'd2, 0);
    run_op("rem", 4'b0110, -64'd7, 64'd2, 0);
    run_op("divu0", 4'b0101, 64'h1234, 64'd0, 0);
    run_op("remu0", 4'b0111, 64'h1234, 64'd0, 0);
    run_op("divovf", 4'b0100, 64'h8000_0000_0000_0000, '1, 0);
    run_op("removf", 4'b0110, 64'h8000_0000_0000_0000, '1, 0);
    run_op("divw", 4'b1100, 64'h0000_0000_8000_0000, 64'd1, 0);
    run_op("mulw", 4'b1000, 64'h7FFF_FFFF, 64'd2, 0);
    run_op("mulh", 4'b0001, -64'd5, 64'h7FFF_FFFF_FFFF_FFFF, 0);
    run_op("mulhsu", 4'b0010, -64'd1, '1, 0);
    run_op("hold", 4'b0101, {$urandom, $urandom}, 64'd977, 30);

    // Flush in cycle 10 of a divide.
    prev = result;
    @(negedge clk); start = 1'b1; op = 4'b0100; a = {$urandom, $urandom}; b = 64'd5;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    check("flush_busy", {63'b0, busy}, 64'd0);
    @(negedge clk); flush = 1'b0;
    seen = 1'b0;
    repeat (80) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    check("flush_nodone", {63'b0, seen}, 64'd0);
    check("flush_res", result, prev);

    // Flush and start together: start is dropped.
    @(negedge clk); start = 1'b1; flush = 1'b1; op = 4'b0000; a = 64'd9; b = 64'd9;
    @(posedge clk); #1;
    check("fs_busy", {63'b0, busy}, 64'd0);
    @(negedge clk); start = 1'b0; flush = 1'b0;
    seen = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    check("fs_nodone", {63'b0, seen}, 64'd0);
    check("fs_res", result, prev);

    // Asynchronous reset in the middle of a divide.
    @(negedge clk); start = 1'b1; op = 4'b0100; a = 64'd1000; b = 64'd7;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    repeat (19) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", {63'b0, busy}, 64'd0);
    check("arst_done", {63'b0, done}, 64'd0);
    check("arst_res", result, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    run_op("post_rst", 4'b0100, 64'd1000, 64'd7, 0);

    for (int i = 0; i < 40; i++) begin
      logic [3:0]  ro;
      logic [63:0] rx, ry;
      ro = 4'($urandom);
      rx = rnd64();
      ry = rnd64();
      run_op($sformatf("rnd%0d_op%h", i, ro), ro, rx, ry, 0);
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
